axis_sink_checker: RTL
======================

# axis_sink_checker

AXI-Stream sink that consumes and checks the counting packet stream produced by the team's stream source. It drives `s_tready`, optionally with pseudo-random backpressure, and checks every accepted beat for data sequence, `tlast` position and `tuser`. It counts packets and errors and captures the first failure. The block sits at the far end of a stream path, such as a loopback or DMA test, as a self-checking endpoint.

## Interface
- `PKG_WIDTH`, 2: packet length is 2^PKG_WIDTH beats; the expected data is the beat index 0 … 2^PKG_WIDTH−1.
- `DATA_WIDTH`, 32: tdata width; must be ≥ PKG_WIDTH.
- `CNT_WIDTH`, 16: width of the packet and error counters.
- `THROTTLE`, 0: 0 means always ready when enabled; 1 means LFSR-gated ready.
- `LFSR_SEED`, 16'hACE1: reset and clear value of the throttle LFSR; must be non-zero.

Ports:
- `clk` in 1: the single clock.
- `rstn` in 1: asynchronous, active-low reset.
- `s_tdata` in DATA_WIDTH: stream data.
- `s_tvalid` in 1: stream valid.
- `s_tready` out 1: stream ready (registered).
- `s_tlast` in 1: end of packet.
- `s_tuser` in 1: must be 0 on every beat.
- `enable` in 1: allows the block to accept beats.
- `clear` in 1: synchronous clear of counters, flags and sequence state.
- `pkt_count` out CNT_WIDTH: number of packets completed with no error; saturates.
- `err_count` out CNT_WIDTH: number of erroneous beats; saturates.
- `err_flags` out 4: sticky error flags {tuser, missing_last, early_last, data}.
- `err_first_exp` out PKG_WIDTH: expected index at the first error.
- `err_first_got` out DATA_WIDTH: tdata received at the first error.

## Operation
- A transfer is a cycle with `s_tvalid && s_tready`. Only transfers are checked or counted.
- State machine with three states:
  - IDLE: `enable`=0, `s_tready`=0. Moves to RECV when `enable`=1.
  - RECV: checks every beat.
  - RESYNC: entered after an erroneous beat that lacks `tlast`. Accepts beats without checking or counting them. On the beat with `tlast`, sets `expected`=0 and returns to RECV.
  - `enable`=0 in RECV or RESYNC goes to IDLE. `expected` and the resync condition are held (a flag remembers RESYNC), so the sequence resumes where it stopped.
- Checks in RECV, where `expected` is a PKG_WIDTH-bit counter:
  - data error: `s_tdata` ≠ zero-extended `expected`.
  - early_last: `tlast`=1 while `expected` ≠ all-ones.
  - missing_last: `tlast`=0 while `expected` = all-ones.
  - tuser: `s_tuser`=1.
- Good beat: `expected` increments modulo 2^PKG_WIDTH (all-ones wraps to 0). If it is the last beat and every beat of the packet was clean, `pkt_count` increments.
- Erroneous beat:
  - `err_count` increments by 1, however many checks failed.
  - The matching `err_flags` bits are set.
  - The first error since reset or clear loads `err_first_exp` and `err_first_got`.
  - If `tlast`=1: `expected`=0 and the state stays RECV. Otherwise: go to RESYNC.
- Counters saturate at all-ones; they never wrap.
- Throttle: a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle while enabled. When THROTTLE=1, ready is allowed only when `lfsr[1:0]` ≠ 2'b00.
- `clear` wins over a simultaneous transfer. That beat is handshaken but neither checked nor counted. Clear sets `expected`=0, counters, flags and first-error captures to 0, and the LFSR to `LFSR_SEED`. The state goes to RECV if `enable`=1, else IDLE.

## Timing
- Reset (`rstn` low, asynchronous, at any time including mid-packet) sets:
  - `s_tready`=0 and state IDLE.
  - `expected`=0, `pkt_count`=0, `err_count`=0, `err_flags`=0.
  - `err_first_exp`=0, `err_first_got`=0, LFSR=`LFSR_SEED`.
- `s_tready` is registered. Next value = next state is RECV/RESYNC ∧ `clear`=0 ∧ throttle permits. `enable` rising → `s_tready` high at the following edge.
- `s_tready` does not depend combinationally on `s_tvalid`. Ready may assert with valid low.
- Status latency: counters, flags and captures update at the clock edge that completes the transfer, and are visible the cycle after.
- With THROTTLE=0 and `enable` held high, the block accepts one beat per cycle indefinitely.

## Structure
- Shared package `axis_sink_pkg`:
  - Error-flag bit indices: ERR_DATA=0, ERR_EARLY_LAST=1, ERR_MISSING_LAST=2, ERR_TUSER=3.
  - State enum {IDLE, RECV, RESYNC}.
  - LFSR tap constant.
- One sub-module, `axis_sink_throttle`: the LFSR plus ready-permit output, with enable and clear inputs. Everything else lives in the top module.

## Test plan
- PKG_WIDTH=2, THROTTLE=0: source sends 0,1,2,3 with tlast on 3, ×3 packets → `pkt_count`=3, `err_count`=0, `err_flags`=0.
- Beat data 0,1,5,3 (tlast on 3) → `err_count`=1, `err_flags`=4'b0001, `err_first_exp`=2, `err_first_got`=5, `pkt_count` unchanged. The next packet 0..3 → `pkt_count`+1.
- tlast on beat 1 (0,1 + last) → early_last set and `expected`=0. Then tlast missing on 3 (0,1,2,3 no last, then 0 with last) → missing_last set, RESYNC swallows the trailing beats, next clean packet counted.
- THROTTLE=1 with continuous valid → `s_tready` low exactly on cycles where `lfsr[1:0]`=0. Data still checks clean over 100 packets.
- Mid-packet `enable` low for 5 cycles after beat 1 → `s_tready`=0 from the next cycle. Resume with beats 2,3 → no error.
- `rstn` pulsed low asynchronously mid-packet with errors recorded → all outputs are 0 immediately. `clear` asserted together with a bad beat → no error recorded.

Source files
------------

// File: rtl/axis_sink_pkg.sv
// -----------------------------------------------------------------------------
// axis_sink_pkg
// Shared definitions for the AXI-Stream sink checker:
//   - bit positions of the sticky error flags
//   - checker state encoding
//   - Fibonacci LFSR tap mask and single-step helper used by the throttle
// -----------------------------------------------------------------------------
package axis_sink_pkg;

    // Bit positions inside err_flags {tuser, missing_last, early_last, data}
    localparam int ERR_DATA         = 0;
    localparam int ERR_EARLY_LAST   = 1;
    localparam int ERR_MISSING_LAST = 2;
    localparam int ERR_TUSER        = 3;
    localparam int ERR_W            = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_RESYNC = 2'd2
    } state_e;

    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One Fibonacci step: shift left, feedback from the tapped bits
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        lfsr_step = {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/axis_sink_throttle.sv
// -----------------------------------------------------------------------------
// axis_sink_throttle
// Free-running 16-bit LFSR used to gate s_tready with pseudo-random
// backpressure. permit_next reflects the LFSR value that will be held after
// the coming clock edge, so a registered ready built from it lines up with
// the LFSR register in the same cycle.
// Ports:
//   clk, rstn    : clock, asynchronous active-low reset
//   enable       : LFSR advances on every clock while high
//   clear        : synchronous reload of LFSR_SEED
//   permit_next  : ready is allowed in the next cycle
// -----------------------------------------------------------------------------
module axis_sink_throttle
    import axis_sink_pkg::*;
#(
    parameter int          THROTTLE  = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rstn,
    input  logic enable,
    input  logic clear,
    output logic permit_next
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next LFSR value: reload on clear, step while enabled, otherwise hold
    always_comb begin
        lfsr_d = lfsr_q;
        if (clear) begin
            lfsr_d = LFSR_SEED;
        end else if (enable) begin
            lfsr_d = lfsr_step(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // Ready permission derived from the upcoming LFSR value
    always_comb begin
        permit_next = 1'b1;
        if (THROTTLE != 0) begin
            permit_next = (lfsr_d[1:0] != 2'b00);
        end else begin
            permit_next = 1'b1;
        end
    end

    // LFSR register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/axis_sink_checker.sv
// -----------------------------------------------------------------------------
// axis_sink_checker
// Self-checking AXI-Stream endpoint for the counting packet stream
// (beat i of every packet carries data i, tlast on the final beat, tuser 0).
// Ports:
//   clk, rstn        : clock, asynchronous active-low reset
//   s_tdata/s_tvalid/s_tready/s_tlast/s_tuser : AXI-Stream slave
//   enable           : allow beats to be accepted
//   clear            : synchronous clear of counters, flags and sequence
//   pkt_count        : clean packets received (saturating)
//   err_count        : erroneous beats received (saturating)
//   err_flags        : sticky {tuser, missing_last, early_last, data}
//   err_first_exp    : expected beat index at the first error
//   err_first_got    : tdata received at the first error
// -----------------------------------------------------------------------------
module axis_sink_checker
    import axis_sink_pkg::*;
#(
    parameter int          PKG_WIDTH  = 2,
    parameter int          DATA_WIDTH = 32,
    parameter int          CNT_WIDTH  = 16,
    parameter int          THROTTLE   = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    input  logic                  s_tuser,
    input  logic                  enable,
    input  logic                  clear,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [ERR_W-1:0]      err_flags,
    output logic [PKG_WIDTH-1:0]  err_first_exp,
    output logic [DATA_WIDTH-1:0] err_first_got
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_e                state_q,  state_d;
    logic                  resync_q, resync_d;
    logic [PKG_WIDTH-1:0]  exp_q,    exp_d;
    logic                  tready_q, tready_d;
    logic [CNT_WIDTH-1:0]  pkt_q,    pkt_d;
    logic [CNT_WIDTH-1:0]  errc_q,   errc_d;
    logic [ERR_W-1:0]      flags_q,  flags_d;
    logic [PKG_WIDTH-1:0]  fexp_q,   fexp_d;
    logic [DATA_WIDTH-1:0] fgot_q,   fgot_d;

    logic                  xfer_s;
    logic                  permit_s;
    logic                  exp_last_s;
    logic [ERR_W-1:0]      beat_flags_s;
    logic                  beat_bad_s;

    axis_sink_throttle #(
        .THROTTLE  (THROTTLE),
        .LFSR_SEED (LFSR_SEED)
    ) u_throttle (
        .clk         (clk),
        .rstn        (rstn),
        .enable      (enable),
        .clear       (clear),
        .permit_next (permit_s)
    );

    assign xfer_s     = s_tvalid & tready_q;
    assign exp_last_s = &exp_q;

    // Per-beat check results against the expected sequence position
    always_comb begin
        beat_flags_s                   = {ERR_W{1'b0}};
        beat_flags_s[ERR_DATA]         = (s_tdata != DATA_WIDTH'(exp_q));
        beat_flags_s[ERR_EARLY_LAST]   = s_tlast & ~exp_last_s;
        beat_flags_s[ERR_MISSING_LAST] = ~s_tlast & exp_last_s;
        beat_flags_s[ERR_TUSER]        = s_tuser;
        beat_bad_s                     = |beat_flags_s;
    end

    // Sequence, counter, flag and capture update for each accepted beat
    always_comb begin
        exp_d    = exp_q;
        resync_d = resync_q;
        pkt_d    = pkt_q;
        errc_d   = errc_q;
        flags_d  = flags_q;
        fexp_d   = fexp_q;
        fgot_d   = fgot_q;
        if (clear) begin
            // A beat handshaken in the same cycle is dropped unchecked
            exp_d    = {PKG_WIDTH{1'b0}};
            resync_d = 1'b0;
            pkt_d    = {CNT_WIDTH{1'b0}};
            errc_d   = {CNT_WIDTH{1'b0}};
            flags_d  = {ERR_W{1'b0}};
            fexp_d   = {PKG_WIDTH{1'b0}};
            fgot_d   = {DATA_WIDTH{1'b0}};
        end else if (xfer_s && (state_q == ST_RECV)) begin
            if (beat_bad_s) begin
                if (errc_q != CNT_MAX) begin
                    errc_d = errc_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    errc_d = errc_q;
                end
                // No flag set yet means this is the first error since clear
                if (flags_q == {ERR_W{1'b0}}) begin
                    fexp_d = exp_q;
                    fgot_d = s_tdata;
                end else begin
                    fexp_d = fexp_q;
                    fgot_d = fgot_q;
                end
                flags_d = flags_q | beat_flags_s;
                if (s_tlast) begin
                    exp_d = {PKG_WIDTH{1'b0}};
                end else begin
                    resync_d = 1'b1;
                end
            end else begin
                // A clean last beat closes a packet whose beats were all clean
                exp_d = exp_q + {{(PKG_WIDTH-1){1'b0}}, 1'b1};
                if (s_tlast && (pkt_q != CNT_MAX)) begin
                    pkt_d = pkt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    pkt_d = pkt_q;
                end
            end
        end else if (xfer_s && (state_q == ST_RESYNC)) begin
            if (s_tlast) begin
                exp_d    = {PKG_WIDTH{1'b0}};
                resync_d = 1'b0;
            end else begin
                exp_d    = exp_q;
            end
        end else begin
            exp_d = exp_q;
        end
    end

    // Next state follows enable; resync_q keeps the resync condition across IDLE
    always_comb begin
        state_d = ST_IDLE;
        if (!enable) begin
            state_d = ST_IDLE;
        end else if (resync_d) begin
            state_d = ST_RESYNC;
        end else begin
            state_d = ST_RECV;
        end
        tready_d = (state_d != ST_IDLE) & ~clear & permit_s;
    end

    // State and status registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            resync_q <= 1'b0;
            exp_q    <= {PKG_WIDTH{1'b0}};
            tready_q <= 1'b0;
            pkt_q    <= {CNT_WIDTH{1'b0}};
            errc_q   <= {CNT_WIDTH{1'b0}};
            flags_q  <= {ERR_W{1'b0}};
            fexp_q   <= {PKG_WIDTH{1'b0}};
            fgot_q   <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            resync_q <= resync_d;
            exp_q    <= exp_d;
            tready_q <= tready_d;
            pkt_q    <= pkt_d;
            errc_q   <= errc_d;
            flags_q  <= flags_d;
            fexp_q   <= fexp_d;
            fgot_q   <= fgot_d;
        end
    end

    assign s_tready      = tready_q;
    assign pkt_count     = pkt_q;
    assign err_count     = errc_q;
    assign err_flags     = flags_q;
    assign err_first_exp = fexp_q;
    assign err_first_got = fgot_q;

endmodule
